// File: rtl/routing_state_manager.sv
// Routing state holder downstream of the system-flit decoder: routing state, own/parent IDs, neighbour table, internal timer.
// Optional watchdog: define ROUTING_STATE_MANAGER_TIMEOUT_EN to force FATAL_ERROR when the timer expires outside NORMAL.
module routing_state_manager #(
    parameter int MAX_INTERNAL_TIMER = 1000,
    parameter int MAX_NEIGHBORS      = 4,
    parameter int INIT_NODE_ID       = 0,
    parameter int NODE_ID_WIDTH      = 8,
    localparam int TIMER_WIDTH       = $clog2(MAX_INTERNAL_TIMER) + 1
) (
    input  logic                                    nocclk,
    input  logic                                    rst_n,
    input  logic                                    flit_valid,
    input  logic                                    is_system_flit,
    input  logic                                    timer_rst,
    input  logic                                    update_parent_valid,
    input  logic [NODE_ID_WIDTH-1:0]                update_parent_node_id,
    input  logic                                    update_this_node_valid,
    input  logic [NODE_ID_WIDTH-1:0]                update_this_node_id,
    input  logic                                    update_neighbor_id_valid,
    input  logic [NODE_ID_WIDTH-1:0]                update_neighbor_id,
    input  logic                                    update_next_state,
    input  logic [2:0]                              next_routing_state,
    output logic [2:0]                              routing_state,
    output logic [NODE_ID_WIDTH-1:0]                this_node_id,
    output logic                                    parent_valid,
    output logic [NODE_ID_WIDTH-1:0]                parent_node_id,
    output logic [TIMER_WIDTH-1:0]                  internal_timer,
    output logic [MAX_NEIGHBORS*NODE_ID_WIDTH-1:0]  neighbor_ids,
    output logic [MAX_NEIGHBORS-1:0]                neighbor_valid,
    output logic                                    neighbor_overflow,
    output logic                                    timeout
);

    typedef enum logic [2:0] {
        INIT        = 3'd0,
        DISCOVERY   = 3'd1,
        JOINING     = 3'd2,
        NORMAL      = 3'd3,
        RECOVERY    = 3'd4,
        FATAL_ERROR = 3'd7
    } routing_state_t;

    localparam logic [TIMER_WIDTH-1:0] TIMER_MAX = TIMER_WIDTH'(MAX_INTERNAL_TIMER);

    routing_state_t                               state_reg, state_next;
    logic [NODE_ID_WIDTH-1:0]                     this_id_reg, this_id_next;
    logic                                         parent_valid_reg, parent_valid_next;
    logic [NODE_ID_WIDTH-1:0]                     parent_id_reg, parent_id_next;
    logic [TIMER_WIDTH-1:0]                       timer_reg, timer_next;
    logic [MAX_NEIGHBORS-1:0][NODE_ID_WIDTH-1:0]  nb_ids_reg, nb_ids_next;
    logic [MAX_NEIGHBORS-1:0]                     nb_valid_reg, nb_valid_next;
    logic                                         overflow_reg, overflow_next;
    logic                                         timeout_reg;

    logic                      accept;
    logic                      state_write;
    logic                      state_change;
    logic                      timer_clear;
    logic                      expire;
    logic [TIMER_WIDTH-1:0]    timer_inc;
    logic [MAX_NEIGHBORS-1:0]  nb_match;
    logic [MAX_NEIGHBORS-1:0]  free_onehot;
    logic                      nb_known;
    logic                      nb_full;

    assign accept       = flit_valid & is_system_flit;
    assign state_write  = accept & update_next_state;
    assign state_change = state_write & (next_routing_state != state_reg);
    assign timer_clear  = state_change | (accept & timer_rst);
    assign timer_inc    = (timer_reg >= TIMER_MAX) ? TIMER_MAX : timer_reg + 1'b1;

`ifdef ROUTING_STATE_MANAGER_TIMEOUT_EN
    // Expiry is the edge on which the timer would reach its ceiling; a decoder state write or a timer clear pre-empts it.
    assign expire = !timer_clear && !state_write
                    && (state_reg != NORMAL) && (state_reg != FATAL_ERROR)
                    && (timer_reg >= TIMER_MAX - 1'b1);
`else
    assign expire = 1'b0;
`endif

    // Duplicate detection against the pre-edge table and own ID.
    for (genvar gi = 0; gi < MAX_NEIGHBORS; gi++) begin : g_match
        assign nb_match[gi] = nb_valid_reg[gi] && (nb_ids_reg[gi] == update_neighbor_id);
    end

    assign nb_known    = (|nb_match) || (update_neighbor_id == this_id_reg);
    assign nb_full     = &nb_valid_reg;
    // Lowest clear bit of the valid vector, one-hot; zero when the table is full.
    assign free_onehot = ~nb_valid_reg & (nb_valid_reg + MAX_NEIGHBORS'(1));

    always_comb begin
        state_next        = state_reg;
        this_id_next      = this_id_reg;
        parent_valid_next = parent_valid_reg;
        parent_id_next    = parent_id_reg;
        nb_ids_next       = nb_ids_reg;
        nb_valid_next     = nb_valid_reg;
        overflow_next     = overflow_reg;
        timer_next        = (timer_clear || expire) ? '0 : timer_inc;

        if (state_write) begin
            state_next = routing_state_t'(next_routing_state);
        end else if (expire) begin
            state_next = FATAL_ERROR;
        end

        if (accept && update_this_node_valid) begin
            this_id_next = update_this_node_id;
        end

        if (accept && update_parent_valid) begin
            parent_valid_next = 1'b1;
            parent_id_next    = update_parent_node_id;
        end

        if (accept && update_neighbor_id_valid && !nb_known) begin
            if (nb_full) begin
                overflow_next = 1'b1;
            end else begin
                for (int i = 0; i < MAX_NEIGHBORS; i++) begin
                    if (free_onehot[i]) begin
                        nb_ids_next[i]   = update_neighbor_id;
                        nb_valid_next[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge nocclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= INIT;
            this_id_reg      <= NODE_ID_WIDTH'(INIT_NODE_ID);
            parent_valid_reg <= 1'b0;
            parent_id_reg    <= '0;
            timer_reg        <= '0;
            nb_ids_reg       <= '0;
            nb_valid_reg     <= '0;
            overflow_reg     <= 1'b0;
            timeout_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            this_id_reg      <= this_id_next;
            parent_valid_reg <= parent_valid_next;
            parent_id_reg    <= parent_id_next;
            timer_reg        <= timer_next;
            nb_ids_reg       <= nb_ids_next;
            nb_valid_reg     <= nb_valid_next;
            overflow_reg     <= overflow_next;
            timeout_reg      <= expire;
        end
    end

    assign routing_state     = state_reg;
    assign this_node_id      = this_id_reg;
    assign parent_valid      = parent_valid_reg;
    assign parent_node_id    = parent_id_reg;
    assign internal_timer    = timer_reg;
    assign neighbor_ids      = nb_ids_reg;
    assign neighbor_valid    = nb_valid_reg;
    assign neighbor_overflow = overflow_reg;
    assign timeout           = timeout_reg;

endmodule

// File: tb/tb_routing_state_manager.sv
// Self-checking bench for routing_state_manager: directed scenarios plus randomized traffic against a queue-based model.
module tb_routing_state_manager;

    localparam int MAXT    = 1000;
    localparam int NN      = 4;
    localparam int NW      = 8;
    localparam int INIT_ID = 5;
    localparam int TW      = $clog2(MAXT) + 1;

    localparam logic [2:0] ST_INIT   = 3'd0;
    localparam logic [2:0] ST_NORMAL = 3'd3;
    localparam logic [2:0] ST_FATAL  = 3'd7;

    logic               nocclk = 1'b0;
    logic               rst_n  = 1'b0;
    logic               flit_valid, is_system_flit, timer_rst;
    logic               update_parent_valid, update_this_node_valid, update_neighbor_id_valid, update_next_state;
    logic [NW-1:0]      update_parent_node_id, update_this_node_id, update_neighbor_id;
    logic [2:0]         next_routing_state;
    logic [2:0]         routing_state;
    logic [NW-1:0]      this_node_id, parent_node_id;
    logic               parent_valid, neighbor_overflow, timeout;
    logic [TW-1:0]      internal_timer;
    logic [NN*NW-1:0]   neighbor_ids;
    logic [NN-1:0]      neighbor_valid;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [2:0]    m_state;
    logic [NW-1:0] m_id, m_pid;
    logic          m_pv, m_ovf, m_to;
    int            m_timer;
    logic [NW-1:0] m_nb[$];

    routing_state_manager #(
        .MAX_INTERNAL_TIMER(MAXT),
        .MAX_NEIGHBORS(NN),
        .INIT_NODE_ID(INIT_ID),
        .NODE_ID_WIDTH(NW)
    ) dut (
        .nocclk(nocclk),
        .rst_n(rst_n),
        .flit_valid(flit_valid),
        .is_system_flit(is_system_flit),
        .timer_rst(timer_rst),
        .update_parent_valid(update_parent_valid),
        .update_parent_node_id(update_parent_node_id),
        .update_this_node_valid(update_this_node_valid),
        .update_this_node_id(update_this_node_id),
        .update_neighbor_id_valid(update_neighbor_id_valid),
        .update_neighbor_id(update_neighbor_id),
        .update_next_state(update_next_state),
        .next_routing_state(next_routing_state),
        .routing_state(routing_state),
        .this_node_id(this_node_id),
        .parent_valid(parent_valid),
        .parent_node_id(parent_node_id),
        .internal_timer(internal_timer),
        .neighbor_ids(neighbor_ids),
        .neighbor_valid(neighbor_valid),
        .neighbor_overflow(neighbor_overflow),
        .timeout(timeout)
    );

    always #5 nocclk = ~nocclk;

    task automatic idle_inputs();
        flit_valid = 0; is_system_flit = 0; timer_rst = 0;
        update_parent_valid = 0; update_parent_node_id = '0;
        update_this_node_valid = 0; update_this_node_id = '0;
        update_neighbor_id_valid = 0; update_neighbor_id = '0;
        update_next_state = 0; next_routing_state = '0;
    endtask

    task automatic model_reset();
        m_state = ST_INIT; m_id = NW'(INIT_ID); m_pv = 0; m_pid = '0;
        m_timer = 0; m_ovf = 0; m_to = 0;
        m_nb.delete();
    endtask

    // One clock edge of the behavioural rules, using the inputs as they stand at the edge.
    task automatic model_step();
        bit acc, clear, known;
        logic [2:0] st;
        acc   = flit_valid && is_system_flit;
        clear = acc && timer_rst;
        st    = m_state;
        m_to  = 0;
        if (acc && update_next_state) begin
            st = next_routing_state;
            if (next_routing_state != m_state) clear = 1;
        end
`ifdef ROUTING_STATE_MANAGER_TIMEOUT_EN
        if (!clear && !(acc && update_next_state) && m_state != ST_NORMAL && m_state != ST_FATAL
            && m_timer + 1 >= MAXT) begin
            m_to = 1; st = ST_FATAL; clear = 1;
        end
`endif
        if (acc && update_neighbor_id_valid) begin
            known = (update_neighbor_id == m_id);
            foreach (m_nb[i]) if (m_nb[i] == update_neighbor_id) known = 1;
            if (!known) begin
                if (m_nb.size() < NN) m_nb.push_back(update_neighbor_id);
                else m_ovf = 1;
            end
        end
        if (acc && update_this_node_valid) m_id = update_this_node_id;
        if (acc && update_parent_valid) begin m_pv = 1; m_pid = update_parent_node_id; end
        m_timer = clear ? 0 : ((m_timer + 1 > MAXT) ? MAXT : m_timer + 1);
        m_state = st;
    endtask

    function automatic logic [NN*NW-1:0] exp_nb_ids();
        logic [NN*NW-1:0] r = '0;
        foreach (m_nb[i]) r[i*NW +: NW] = m_nb[i];
        return r;
    endfunction

    function automatic logic [NN-1:0] exp_nb_valid();
        logic [NN-1:0] r = '0;
        foreach (m_nb[i]) r[i] = 1'b1;
        return r;
    endfunction

    task automatic tick();
        @(posedge nocclk);
        model_step();
        @(negedge nocclk);
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge nocclk);
        rst_n = 0;
        @(negedge nocclk);
        rst_n = 1;
        model_reset();
    endtask

    task automatic send_accepted();
        flit_valid = 1; is_system_flit = 1;
    endtask

    task automatic test_reset();
        do_reset();
        send_accepted();
        update_next_state = 1; next_routing_state = ST_NORMAL;
        update_this_node_valid = 1; update_this_node_id = 8'h09;
        update_parent_valid = 1; update_parent_node_id = 8'h21;
        update_neighbor_id_valid = 1; update_neighbor_id = 8'h02;
        tick();
        idle_inputs();
        tick();
        #2 rst_n = 0;
        #1;
        vectors++;
        if ({routing_state, this_node_id, parent_valid, parent_node_id, internal_timer, neighbor_ids,
             neighbor_valid, neighbor_overflow, timeout} !==
            {ST_INIT, NW'(INIT_ID), 1'b0, NW'(0), TW'(0), (NN*NW)'(0), NN'(0), 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_async: state=%0d id=%0h pv=%b pid=%0h t=%0d nv=%b expected all reset values",
                     routing_state, this_node_id, parent_valid, parent_node_id, internal_timer, neighbor_valid);
        end
        @(negedge nocclk);
        rst_n = 1;
        model_reset();
        #1;
        vectors++;
        if (this_node_id !== NW'(INIT_ID)) begin
            miscompares++;
            $display("FAIL reset_node_id: got %0d expected %0d", this_node_id, INIT_ID);
        end
        vectors++;
        if ({routing_state, parent_valid, internal_timer, neighbor_valid, neighbor_overflow, timeout} !==
            {ST_INIT, 1'b0, TW'(0), NN'(0), 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_release: state=%0d pv=%b t=%0d nv=%b ovf=%b to=%b expected 0",
                     routing_state, parent_valid, internal_timer, neighbor_valid, neighbor_overflow, timeout);
        end
        @(negedge nocclk);
        vectors++;
        if (internal_timer !== TW'(1)) begin
            miscompares++;
            $display("FAIL reset_first_inc: got %0d expected 1", internal_timer);
        end
        model_step();
        $display("test_reset done");
    endtask

    task automatic test_accepted_updates();
        do_reset();
        repeat (3) tick();
        send_accepted();
        update_next_state = 1; next_routing_state = ST_NORMAL;
        update_parent_valid = 1; update_parent_node_id = 8'h00;
        tick();
        idle_inputs();
        vectors++;
        if (routing_state !== ST_NORMAL || parent_valid !== 1'b1 || parent_node_id !== 8'h00
            || internal_timer !== TW'(0)) begin
            miscompares++;
            $display("FAIL accepted_updates: state=%0d pv=%b pid=%0h t=%0d expected 3 1 0 0",
                     routing_state, parent_valid, parent_node_id, internal_timer);
        end
        $display("test_accepted_updates done");
    endtask

    task automatic test_neighbors();
        logic [NW-1:0] seq1[5] = '{8'd2, 8'd3, 8'd3, 8'd2, 8'd1};
        logic [NW-1:0] seq2[3] = '{8'd4, 8'd5, 8'd6};
        do_reset();
        send_accepted();
        update_this_node_valid = 1; update_this_node_id = 8'd1;
        tick();
        idle_inputs();
        foreach (seq1[i]) begin
            send_accepted();
            update_neighbor_id_valid = 1; update_neighbor_id = seq1[i];
            tick();
        end
        idle_inputs();
        vectors++;
        if (neighbor_valid !== 4'b0011 || neighbor_ids[15:0] !== 16'h0302 || neighbor_overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL nb_dedup: valid=%b ids=%h ovf=%b expected 0011 ....0302 0",
                     neighbor_valid, neighbor_ids, neighbor_overflow);
        end
        foreach (seq2[i]) begin
            send_accepted();
            update_neighbor_id_valid = 1; update_neighbor_id = seq2[i];
            tick();
        end
        idle_inputs();
        vectors++;
        if (neighbor_valid !== 4'b1111 || neighbor_ids !== 32'h05040302 || neighbor_overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL nb_full: valid=%b ids=%h ovf=%b expected 1111 05040302 1",
                     neighbor_valid, neighbor_ids, neighbor_overflow);
        end
        $display("test_neighbors done");
    endtask

    task automatic test_gating();
        do_reset();
        flit_valid = 1; is_system_flit = 0;
        update_this_node_valid = 1; update_this_node_id = 8'h77;
        update_next_state = 1; next_routing_state = ST_NORMAL;
        update_neighbor_id_valid = 1; update_neighbor_id = 8'h33;
        tick();
        vectors++;
        if (this_node_id !== NW'(INIT_ID) || routing_state !== ST_INIT || neighbor_valid !== 4'b0000) begin
            miscompares++;
            $display("FAIL gating_not_system: id=%0h state=%0d nv=%b expected %0h 0 0000",
                     this_node_id, routing_state, neighbor_valid, INIT_ID);
        end
        flit_valid = 0; is_system_flit = 1;
        tick();
        idle_inputs();
        vectors++;
        if (this_node_id !== NW'(INIT_ID) || routing_state !== ST_INIT || internal_timer !== TW'(2)) begin
            miscompares++;
            $display("FAIL gating_not_valid: id=%0h state=%0d t=%0d expected %0h 0 2",
                     this_node_id, routing_state, internal_timer, INIT_ID);
        end
        $display("test_gating done");
    endtask

    task automatic test_timer();
        do_reset();
        for (int c = 0; c < MAXT + 6; c++) begin
            tick();
            vectors++;
            if (internal_timer !== TW'(m_timer) || timeout !== m_to || routing_state !== m_state) begin
                miscompares++;
                $display("FAIL timer_run cyc %0d: t=%0d to=%b st=%0d expected %0d %b %0d",
                         c, internal_timer, timeout, routing_state, m_timer, m_to, m_state);
            end
        end
`ifndef ROUTING_STATE_MANAGER_TIMEOUT_EN
        vectors++;
        if (internal_timer !== TW'(MAXT)) begin
            miscompares++;
            $display("FAIL timer_saturate: got %0d expected %0d", internal_timer, MAXT);
        end
`endif
        do_reset();
        repeat (500) tick();
        send_accepted();
        timer_rst = 1;
        tick();
        idle_inputs();
        vectors++;
        if (internal_timer !== TW'(0)) begin
            miscompares++;
            $display("FAIL timer_clear: got %0d expected 0", internal_timer);
        end
        tick();
        vectors++;
        if (internal_timer !== TW'(1)) begin
            miscompares++;
            $display("FAIL timer_after_clear: got %0d expected 1", internal_timer);
        end
        $display("test_timer done");
    endtask

    task automatic test_timeout();
        do_reset();
        repeat (MAXT - 1) tick();
        tick();
`ifdef ROUTING_STATE_MANAGER_TIMEOUT_EN
        vectors++;
        if (timeout !== 1'b1 || routing_state !== ST_FATAL || internal_timer !== TW'(0)) begin
            miscompares++;
            $display("FAIL timeout_fire: to=%b st=%0d t=%0d expected 1 7 0", timeout, routing_state, internal_timer);
        end
        tick();
        vectors++;
        if (timeout !== 1'b0 || routing_state !== ST_FATAL) begin
            miscompares++;
            $display("FAIL timeout_pulse_len: to=%b st=%0d expected 0 7", timeout, routing_state);
        end
`else
        vectors++;
        if (timeout !== 1'b0 || routing_state !== ST_INIT || internal_timer !== TW'(MAXT)) begin
            miscompares++;
            $display("FAIL no_timeout: to=%b st=%0d t=%0d expected 0 0 %0d",
                     timeout, routing_state, internal_timer, MAXT);
        end
`endif
        do_reset();
        repeat (MAXT - 1) tick();
        send_accepted();
        update_next_state = 1; next_routing_state = ST_NORMAL;
        tick();
        idle_inputs();
        vectors++;
        if (timeout !== 1'b0 || routing_state !== ST_NORMAL || internal_timer !== TW'(0)) begin
            miscompares++;
            $display("FAIL timeout_preempt: to=%b st=%0d t=%0d expected 0 3 0", timeout, routing_state, internal_timer);
        end
        $display("test_timeout done");
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            flit_valid               = ($urandom_range(0, 3) != 0);
            is_system_flit           = ($urandom_range(0, 3) != 0);
            timer_rst                = ($urandom_range(0, 15) == 0);
            update_parent_valid      = ($urandom_range(0, 7) == 0);
            update_parent_node_id    = NW'($urandom_range(0, 9));
            update_this_node_valid   = ($urandom_range(0, 15) == 0);
            update_this_node_id      = NW'($urandom_range(0, 9));
            update_neighbor_id_valid = ($urandom_range(0, 2) == 0);
            update_neighbor_id       = NW'($urandom_range(0, 9));
            update_next_state        = ($urandom_range(0, 5) == 0);
            next_routing_state       = 3'($urandom_range(0, 7));
            if (c % 500 == 499) begin
                do_reset();
            end else begin
                tick();
            end
            vectors++;
            if (routing_state !== m_state || this_node_id !== m_id || parent_valid !== m_pv
                || parent_node_id !== m_pid || internal_timer !== TW'(m_timer) || timeout !== m_to
                || neighbor_ids !== exp_nb_ids() || neighbor_valid !== exp_nb_valid()
                || neighbor_overflow !== m_ovf) begin
                miscompares++;
                $display("FAIL random cyc %0d: st=%0d id=%0h pv=%b pid=%0h t=%0d to=%b ids=%h nv=%b ovf=%b expected st=%0d id=%0h pv=%b pid=%0h t=%0d to=%b ids=%h nv=%b ovf=%b",
                         c, routing_state, this_node_id, parent_valid, parent_node_id, internal_timer, timeout,
                         neighbor_ids, neighbor_valid, neighbor_overflow, m_state, m_id, m_pv, m_pid, m_timer,
                         m_to, exp_nb_ids(), exp_nb_valid(), m_ovf);
            end
        end
        idle_inputs();
        $display("test_random done");
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_accepted_updates();
        test_neighbors();
        test_gating();
        test_timer();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/routing_state_manager.md
# routing_state_manager

Sequential state holder that sits directly downstream of the system-flit decoder in the router's packet controller. It registers the decoder's update requests into the node's routing state, own node ID, parent ID and neighbour table. It also runs the internal timer that it feeds back to the decoder. The decoder reads `routing_state`, `this_node_id` and `internal_timer` from this block, which closes the loop.

## Interface
Reset is asynchronous and active-low on `rst_n`; single clock `nocclk`.

Parameters:
- `MAX_INTERNAL_TIMER`, 1000: timer saturation value. Must equal the decoder's value.
- `MAX_NEIGHBORS`, 4: neighbour table depth (≥1).
- `INIT_NODE_ID`, 0: `this_node_id` after reset.

Ports:
- `nocclk`  in  1  clock
- `rst_n`  in  1  async active-low reset
- `flit_valid`  in  1  decoder input flit valid
- `is_system_flit`  in  1  decoder: flit is SYSTEM type
- `timer_rst`  in  1  decoder: clear timer
- `update_parent_valid` / `update_parent_node_id`  in  1 / node_id_t  parent write
- `update_this_node_valid` / `update_this_node_id`  in  1 / node_id_t  own-ID write
- `update_neighbor_id_valid` / `update_neighbor_id`  in  1 / node_id_t  neighbour insert
- `update_next_state` / `next_routing_state`  in  1 / routing_state_t  state write
- `routing_state`  out  routing_state_t  current state
- `this_node_id`  out  node_id_t  own ID
- `parent_valid` / `parent_node_id`  out  1 / node_id_t  registered parent
- `internal_timer`  out  $clog2(MAX_INTERNAL_TIMER)+1  timer
- `neighbor_ids`  out  MAX_NEIGHBORS×node_id_t  table entries
- `neighbor_valid`  out  MAX_NEIGHBORS  per-entry valid
- `neighbor_overflow`  out  1  sticky: insert dropped because table was full
- `timeout`  out  1  one-cycle pulse on timer expiry

## Operation
- `accept = flit_valid & is_system_flit`. All `update_*` and `timer_rst` inputs are ignored when `accept` is 0.
- **State:** on `accept & update_next_state`, `routing_state <= next_routing_state`. No other legality check is applied; the decoder owns the transition rules.
- **Own ID:** on `accept & update_this_node_valid`, `this_node_id <= update_this_node_id`.
- **Parent:** on `accept & update_parent_valid`, `parent_node_id <=` the new ID and `parent_valid <= 1`. `parent_valid` clears only on reset.
- **Neighbours:** on `accept & update_neighbor_id_valid`:
  - If the ID equals the current `this_node_id`, or matches any valid entry, there is no change.
  - Otherwise the ID is written into the lowest-index invalid slot and that slot's valid bit is set.
  - If there is no free slot, the insert is dropped and `neighbor_overflow <= 1`.
  - Entries are never removed except by reset.
- **Timer:**
  - Clears to 0 on `accept & timer_rst` and on any actual state change.
  - Otherwise increments by 1 each cycle and saturates at `MAX_INTERNAL_TIMER`; it never wraps.
- **Simultaneous events:** updates to distinct registers in the same cycle all take effect. Timer clear wins over increment.

## Timing
- Reset values:
  - `routing_state = INIT`, `this_node_id = INIT_NODE_ID`
  - `parent_valid = 0`, `parent_node_id = 0`
  - `internal_timer = 0`
  - `neighbor_ids = 0`, `neighbor_valid = 0`
  - `neighbor_overflow = 0`, `timeout = 0`
- Every update is visible on the outputs 1 cycle after the accepting edge. All outputs are registered, with no combinational input-to-output path.
- The duplicate check uses the table contents before the edge. Re-sending the same ID on consecutive accepted cycles is still a no-op.
- Reset asserted mid-operation clears all state immediately (asynchronously). The first increment occurs on the first edge after reset deasserts.

## Configuration
- **`ROUTING_STATE_MANAGER_TIMEOUT_EN` defined:**
  - Expiry occurs on the edge where the timer reaches `MAX_INTERNAL_TIMER` while `routing_state != NORMAL` and `routing_state != FATAL_ERROR`.
  - On that edge the block pulses `timeout` for 1 cycle, forces `routing_state <= FATAL_ERROR` and clears the timer.
  - An accepted `update_next_state` in the same cycle wins: there is no timeout, and the decoder's state is applied.
- **Undefined:** `timeout` is tied to 0, the timer only saturates, and there is no forced transition.

## Test plan
- **Reset values:** assert reset, then release → every output equals its listed reset value. With `INIT_NODE_ID=5`, `this_node_id=5`.
- **Accepted updates:** accepted flit with `update_next_state`, `next_routing_state=NORMAL`, `update_parent_valid`, parent ID 0 → next cycle shows `routing_state=NORMAL`, `parent_valid=1`, `parent_node_id=0`, timer 0.
- **Neighbour table, `MAX_NEIGHBORS=4`:**
  - Insert 2, 3, 2, then own ID 1 → `neighbor_valid=0b0011` and slots hold 2 and 3.
  - Then insert 4, 5, 6 → `valid=0b1111` and `neighbor_overflow=1`.
- **Gating:** `update_this_node_valid=1` with `is_system_flit=0` → `this_node_id` unchanged.
- **Timer:** from INIT with no traffic, the timer counts to 1000 and holds. An accepted `timer_rst` at count 500 → 0 on the next cycle, then 1.
- **Timeout, with `ROUTING_STATE_MANAGER_TIMEOUT_EN`:**
  - In INIT, the timer reaches 1000 → 1-cycle `timeout` pulse, `routing_state=FATAL_ERROR`, timer 0.
  - An accepted `update_next_state` to NORMAL on the expiry cycle → NORMAL and no pulse.
